// File: rtl/uart_debugger_pkg.sv
// Shared definitions for the UART debug bridge: the snapshot command byte,
// 8N1 frame constants and the receive/transmit state encodings.
package uart_debugger_pkg;

  localparam logic [7:0] CMD_SNAPSHOT   = 8'h4C;  // ASCII 'L'
  localparam int         UART_DATA_BITS = 8;
  localparam int         UART_STOP_BITS = 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/uart_debugger_tx.sv
// 8N1 UART transmitter with a byte/valid/ready handshake.
// A byte offered with valid_i while ready_o is high is taken on that edge and
// its start bit appears on tx_o immediately. ready_o is also high in the last
// cycle of the final stop bit, so bytes chain back-to-back with no idle gap.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   valid_i,byte_i byte to send
//   ready_o        byte will be accepted on this edge if valid_i is high
//   busy_o         a frame is in progress
//   tx_o           serial line, idle high
module uart_debugger_tx
  import uart_debugger_pkg::*;
#(
  parameter int DIVIDER_TICKS_WIDTH = 10,
  parameter int DIVIDER_TICKS       = 1023
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] byte_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       tx_o
);

  tx_state_e                      state_q;
  logic [DIVIDER_TICKS_WIDTH-1:0] cnt_q;
  logic [2:0]                     bit_q;
  logic [7:0]                     sh_q;
  logic                           tx_q;
  logic                           bit_end;
  logic                           last_stop;

  assign bit_end   = (cnt_q == DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1));
  assign last_stop = (state_q == TX_STOP) && bit_end &&
                     (bit_q == 3'(UART_STOP_BITS - 1));
  assign ready_o   = (state_q == TX_IDLE) || last_stop;
  assign busy_o    = (state_q != TX_IDLE);
  assign tx_o      = tx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else if (valid_i && ready_o) begin
      state_q <= TX_START;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= byte_i;
      tx_q    <= 1'b0;
    end else if (state_q != TX_IDLE) begin
      if (!bit_end) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
        case (state_q)
          TX_START: begin
            state_q <= TX_DATA;
            tx_q    <= sh_q[0];
          end
          TX_DATA: begin
            if (bit_q == 3'(UART_DATA_BITS - 1)) begin
              state_q <= TX_STOP;
              bit_q   <= '0;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
              sh_q  <= {1'b0, sh_q[7:1]};
              tx_q  <= sh_q[1];
            end
          end
          TX_STOP: begin
            if (last_stop) begin
              state_q <= TX_IDLE;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
            tx_q <= 1'b1;
          end
          TX_IDLE: state_q <= TX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_debugger.sv
// UART debug bridge. Receives one-byte commands on debug_uart_rx_in; the byte
// 'L' captures data_in and transmits it MSB byte first on tx_out, pulsing
// debug_start for one cycle on the capture edge.
// Ports:
//   clk_in            clock (rising edge)
//   reset             synchronous active-high reset
//   data_in           status word sampled at snapshot time
//   debug_uart_rx_in  asynchronous 8N1 receive line, idle high
//   tx_out            8N1 transmit line, idle high
//   debug_start       one-cycle snapshot strobe
module uart_debugger
  import uart_debugger_pkg::*;
#(
  parameter int DIVIDER_TICKS_WIDTH = 10,
  parameter int DIVIDER_TICKS       = 1023,
  parameter int DATA_WIDTH          = 24
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  debug_uart_rx_in,
  output logic                  tx_out,
  output logic                  debug_start
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BCW    = $clog2(NBYTES + 1);
  localparam int HALF   = DIVIDER_TICKS / 2;

  // Receiver
  logic                           rx_s1_q, rx_s2_q;
  logic                           rx_prev_q;  // also the arm flag: 0 until a synchronized 1 is seen
  rx_state_e                      rx_state_q;
  logic [DIVIDER_TICKS_WIDTH-1:0] rx_cnt_q;
  logic [2:0]                     rx_bit_q;
  logic [7:0]                     rx_byte_q;
  logic                           rx_bit_end;

  // Snapshot control
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BCW-1:0]        bytes_left_q;
  logic                  debug_start_q;
  logic                  tx_ready, tx_busy, tx_valid, next_byte, burst_busy, snapshot;
  logic [7:0]            tx_byte;

  assign rx_bit_end = (rx_cnt_q == DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1));
  assign burst_busy = tx_busy || (bytes_left_q != '0);
  // Stop-bit sample cycle of a good 'L' frame while the transmitter is free.
  assign snapshot   = (rx_state_q == RX_STOP) && rx_bit_end && rx_s2_q &&
                      (rx_byte_q == CMD_SNAPSHOT) && !burst_busy;
  assign next_byte  = (bytes_left_q != '0) && tx_ready;
  assign tx_valid   = snapshot || next_byte;
  // The first byte goes straight from data_in so TX starts on the capture edge.
  assign tx_byte    = snapshot ? data_in[DATA_WIDTH-1 -: 8] : shift_q[DATA_WIDTH-1 -: 8];
  assign debug_start = debug_start_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_s1_q    <= 1'b0;
      rx_s2_q    <= 1'b0;
      rx_prev_q  <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_byte_q  <= '0;
    end else begin
      rx_s1_q   <= debug_uart_rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == DIVIDER_TICKS_WIDTH'(HALF)) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;  // high here means a glitch
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_cnt_q  <= '0;
            rx_byte_q <= {rx_s2_q, rx_byte_q[7:1]};
            rx_bit_q  <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'(UART_DATA_BITS - 1)) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          // A low stop bit drops the byte; IDLE then needs a fresh 1->0 edge.
          if (rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      shift_q       <= '0;
      bytes_left_q  <= '0;
      debug_start_q <= 1'b0;
    end else begin
      debug_start_q <= snapshot;
      if (snapshot) begin
        shift_q      <= data_in << 8;
        bytes_left_q <= BCW'(NBYTES - 1);
      end else if (next_byte) begin
        shift_q      <= shift_q << 8;
        bytes_left_q <= bytes_left_q - 1'b1;
      end
    end
  end

  uart_debugger_tx #(
    .DIVIDER_TICKS_WIDTH(DIVIDER_TICKS_WIDTH),
    .DIVIDER_TICKS      (DIVIDER_TICKS)
  ) u_tx (
    .clk_i  (clk_in),
    .rst_i  (reset),
    .valid_i(tx_valid),
    .byte_i (tx_byte),
    .ready_o(tx_ready),
    .busy_o (tx_busy),
    .tx_o   (tx_out)
  );

endmodule

// File: tb/tb_uart_debugger.sv
module tb_uart_debugger;

  localparam int DIV = 21;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] data_in;
  logic        rx;
  logic        tx_out;
  logic        debug_start;

  int compared = 0;
  int failed   = 0;
  int ds_cnt   = 0;
  int tx_low   = 0;
  int base_ds, base_low, w;

  uart_debugger #(
    .DIVIDER_TICKS_WIDTH(5),
    .DIVIDER_TICKS      (DIV),
    .DATA_WIDTH         (24)
  ) dut (
    .clk_in          (clk),
    .reset           (reset),
    .data_in         (data_in),
    .debug_uart_rx_in(rx),
    .tx_out          (tx_out),
    .debug_start     (debug_start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (debug_start === 1'b1) ds_cnt++;
    if (tx_out === 1'b0) tx_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  // Waits for the strobe, then checks every cycle of the 30-bit burst.
  task automatic check_burst(input logic [23:0] exp, input string tag);
    int          waited;
    int          bad;
    logic        e;
    logic        first_obs;
    logic [7:0]  b;
    waited = 0;
    while (debug_start !== 1'b1 && waited < 15 * DIV) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_strobe"}, debug_start, 1);
    if (debug_start !== 1'b1) return;
    data_in = ~exp;
    for (int k = 0; k < 3; k++) begin
      b = exp[23 - 8 * k -: 8];
      for (int j = 0; j < 10; j++) begin
        e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j - 1];
        bad = 0;
        first_obs = e;
        for (int c = 0; c < DIV; c++) begin
          if (k == 0 && j == 0 && c == 1) chk({tag, "_pulse_width"}, debug_start, 0);
          if (tx_out !== e) begin
            if (bad == 0) first_obs = tx_out;
            bad++;
          end
          @(negedge clk);
        end
        compared++;
        assert (bad == 0) else begin
          failed++;
          $error("FAIL %s_byte%0d_bit%0d observed=%b expected=%b (bad cycles %0d)",
                 tag, k, j, first_obs, e, bad);
        end
      end
    end
    chk({tag, "_idle_after"}, tx_out, 1);
  endtask

  initial begin
    reset   = 1'b1;
    rx      = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_out, 1);
    chk("rst_strobe", debug_start, 0);
    reset = 1'b0;
    repeat (5000) @(negedge clk);
    chk("low_line_strobes", ds_cnt, 0);
    chk("low_line_tx_low", tx_low, 0);

    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);

    // Basic snapshot
    data_in = 24'hF0AA0D;
    fork
      send_byte(8'h4C, 1'b1);
      check_burst(24'hF0AA0D, "basic");
    join
    chk("basic_count", ds_cnt, 1);

    // Non-command bytes
    base_ds = ds_cnt; base_low = tx_low;
    send_byte(8'h62, 1'b1);
    send_byte(8'h72, 1'b1);
    send_byte(8'h52, 1'b1);
    send_byte(8'h20, 1'b1);
    repeat (2 * DIV) @(negedge clk);
    chk("ignored_strobes", ds_cnt, base_ds);
    chk("ignored_tx_low", tx_low, base_low);

    // 'L' while busy is dropped; 'L' after idle samples the new data
    base_ds = ds_cnt;
    data_in = 24'h123456;
    fork
      send_byte(8'h4C, 1'b1);
      check_burst(24'h123456, "busy1");
      begin
        repeat (12 * DIV) @(negedge clk);
        send_byte(8'h4C, 1'b1);
      end
    join
    chk("busy_one_burst", ds_cnt, base_ds + 1);
    repeat (2 * DIV) @(negedge clk);
    data_in = 24'hC35A81;
    fork
      send_byte(8'h4C, 1'b1);
      check_burst(24'hC35A81, "busy3");
    join

    // Glitch start and bad stop bit
    base_ds = ds_cnt; base_low = tx_low;
    rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    send_byte(8'h4C, 1'b0);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    chk("framing_strobes", ds_cnt, base_ds);
    chk("framing_tx_low", tx_low, base_low);

    // Reset in the middle of the second byte
    data_in = 24'hF0AA0D;
    fork
      send_byte(8'h4C, 1'b1);
      begin
        w = 0;
        while (debug_start !== 1'b1 && w < 15 * DIV) begin
          @(negedge clk);
          w++;
        end
        chk("midrst_strobe", debug_start, 1);
        repeat (13 * DIV) @(negedge clk);
        chk("midrst_bit13", tx_out, 0);
      end
    join
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_tx_high", tx_out, 1);
    chk("midrst_strobe_low", debug_start, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base_ds = ds_cnt; base_low = tx_low;
    repeat (25 * DIV) @(negedge clk);
    chk("midrst_no_more_bits", tx_low, base_low);
    chk("midrst_no_strobe", ds_cnt, base_ds);

    data_in = 24'h0D55E7;
    fork
      send_byte(8'h4C, 1'b1);
      check_burst(24'h0D55E7, "after_rst");
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/uart_debugger.md
# uart_debugger

UART debug bridge: listens on a serial receive line for a one-byte command and answers by transmitting a snapshot of a parallel status word, MSB byte first. It sits at the top level beside the display logic, giving a host PC read access to internal state over a single TX/RX pair. It also announces each snapshot with a one-cycle strobe.

## Interface
- DIVIDER_TICKS_WIDTH, 10: width of the bit-period counters; must satisfy 2^DIVIDER_TICKS_WIDTH > DIVIDER_TICKS.
- DIVIDER_TICKS, 1023: clk_in cycles per UART bit, used for both RX and TX.
- DATA_WIDTH, 24: width of data_in; must be a nonzero multiple of 8.
- clk_in  input  1  sole clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  status word sampled at snapshot time.
- debug_uart_rx_in  input  1  asynchronous UART receive line, idle high, 8N1.
- tx_out  output  1  UART transmit line, idle high, 8N1.
- debug_start  output  1  one-cycle pulse marking snapshot capture and TX start.

## Operation
- RX front end:
  - debug_uart_rx_in passes through a 2-flop synchronizer.
  - The receiver arms only after it has seen a synchronized 1. A line held low from reset never starts a frame.
- RX frame:
  - A synchronized 1->0 transition starts a frame.
  - After DIVIDER_TICKS/2 cycles, the start bit is re-sampled. If it reads 1, the frame is aborted and the receiver returns to idle.
  - 8 data bits, LSB first, are then sampled at DIVIDER_TICKS intervals.
  - The stop bit is sampled DIVIDER_TICKS later. If it reads 0, the byte is discarded (framing error) and the receiver waits for the line to return high.
- RX states: IDLE, START, DATA, STOP.
- Command decoding:
  - A valid byte equal to 0x4C ('L') is a snapshot command.
  - All other bytes are ignored.
  - Commands arriving while TX is busy are ignored, but the receiver keeps running.
- Snapshot:
  - data_in is latched into a shift register.
  - debug_start pulses high for exactly one cycle.
  - TX sends DATA_WIDTH/8 bytes, most significant byte first.
  - Each byte is framed as: start 0, 8 data bits LSB first, stop 1.
  - Bytes are sent back-to-back with no idle gap.
- TX states: IDLE, START, DATA, STOP. A byte counter selects the next byte and returns to IDLE after the last byte.
- Reset at any time:
  - Both state machines go to IDLE and the receiver disarms.
  - tx_out goes to 1 and debug_start goes to 0 on the reset edge.
  - Any partial frame is abandoned, with no resume.

## Timing
- Reset values: tx_out=1, debug_start=0; all counters 0; shift register 0.
- Command latency: the stop-bit sample edge of a valid 'L' frame is cycle S. On the rising edge ending cycle S:
  - data_in is captured;
  - debug_start goes to 1 and stays high for one cycle;
  - tx_out goes to 0.
- Bit timing: each TX bit holds for exactly DIVIDER_TICKS cycles.
- Frame and burst length: one frame = 10*DIVIDER_TICKS cycles. The full burst = (DATA_WIDTH/8)*10*DIVIDER_TICKS cycles, after which tx_out stays 1.
- data_in changes after capture do not affect the burst in progress.
- The earliest next snapshot is the first 'L' whose stop-bit sample falls on or after the cycle TX returns to IDLE.
- Bit-period counters count 0..DIVIDER_TICKS-1 and wrap; the half-bit wait uses floor(DIVIDER_TICKS/2).

## Structure
- Shared package holds:
  - the command constant CMD_SNAPSHOT = 8'h4C;
  - RX/TX state enums;
  - UART frame constants (8 data bits, 1 stop bit).
- One natural sub-module: uart_tx (byte-in/valid/busy, parameterized by DIVIDER_TICKS). Receiver and control stay in the top.
- The existing clock_divider (CLK_DIV_COUNT, CLK_DIV_WIDTH; reset, clk_in, clk_out) is not used internally. Baud timing comes from in-block counters.

## Test plan
- Reset state: hold reset 3 cycles with rx low, then release with rx low for 5000 cycles -> tx_out=1, debug_start=0 throughout, no frame is started.
- Basic snapshot: DIVIDER_TICKS=1023, data_in=24'hF0AA0D, send 'L' -> debug_start pulses for 1 cycle, and tx_out carries bytes F0, AA, 0D, LSB first, each bit exactly 1023 cycles, 30690 cycles total.
- Ignored bytes: send 'b','r','R',' ' -> no debug_start pulse, tx_out stays 1.
- Busy command: send a second 'L' mid-burst -> exactly one burst is sent; a third 'L' after idle produces a new burst carrying the current data_in.
- Framing errors: send a glitch start (low for DIVIDER_TICKS/4), then an 'L' frame with stop bit 0 -> both are discarded, no response.
- Reset mid-operation: assert reset during the second TX byte -> tx_out=1 next edge, no further bits are sent, and a fresh 'L' afterwards gives a full 3-byte burst.
